// File: rtl/ram_7x17_access_ctrl_pkg.sv
// ram_7x17_access_ctrl_pkg: default sizes, FSM states and opcodes for the 7x17 storage controller
package ram_7x17_access_ctrl_pkg;
   localparam int DEF_DW    = 17;
   localparam int DEF_AW    = 3;
   localparam int DEF_DEPTH = 7;
   localparam int DEF_CNT_W = 8;
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EXEC, S_RESP} state_t;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/ram_7x17_access_ctrl_clear_seq.sv
// ram_7x17_access_ctrl_clear_seq: address counter and done flag for the post-reset zero sweep (RAM_CTRL_INIT_CLEAR_EN)
module ram_7x17_access_ctrl_clear_seq
   import ram_7x17_access_ctrl_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [AW-1:0] addr,
   output logic          done
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   assign done = addr == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) addr <= '0;
      else if (en && !done) addr <= addr + 1'b1;
endmodule

// File: rtl/ram_7x17_access_ctrl.sv
// ram_7x17_access_ctrl: command/response initiator for the 7x17 2R1W storage; RAM_CTRL_INIT_CLEAR_EN adds a post-reset zero sweep
module ram_7x17_access_ctrl
   import ram_7x17_access_ctrl_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic [AW-1:0]    cmd_addr_a,
   input  logic [AW-1:0]    cmd_addr_b,
   input  logic [DW-1:0]    cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_data_a,
   output logic [DW-1:0]    rsp_data_b,
   output logic             rsp_err,
   output logic [AW-1:0]    ram_ra1,
   output logic [AW-1:0]    ram_ra2,
   output logic [AW-1:0]    ram_wa,
   output logic [DW-1:0]    ram_wd,
   output logic             ram_we,
   input  logic [DW-1:0]    ram_rd1,
   input  logic [DW-1:0]    ram_rd2,
   output logic [CNT_W-1:0] op_count
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t state;
   logic op_q, err_q, accept, cmd_err;
   assign accept  = cmd_valid & cmd_ready;
   assign cmd_err = (cmd_addr_a > LAST) | ((cmd_op == OP_READ) & (cmd_addr_b > LAST));
`ifdef RAM_CTRL_INIT_CLEAR_EN
   localparam state_t RST_STATE = S_CLEAR;
   logic [AW-1:0] clr_addr;
   logic clr_done;
   ram_7x17_access_ctrl_clear_seq #(.AW(AW), .DEPTH(DEPTH)) u_clear_seq (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (state == S_CLEAR),
      .addr (clr_addr),
      .done (clr_done)
   );
`else
   localparam state_t RST_STATE = S_IDLE;
`endif
   // storage ports are registered at accept so the write strobe lands exactly in the EXEC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST_STATE;
         op_q       <= OP_READ;
         err_q      <= 1'b0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data_a <= '0;
         rsp_data_b <= '0;
         rsp_err    <= 1'b0;
         ram_ra1    <= '0;
         ram_ra2    <= '0;
         ram_wa     <= '0;
         ram_wd     <= '0;
         ram_we     <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
`ifdef RAM_CTRL_INIT_CLEAR_EN
            S_CLEAR: begin
               ram_we <= 1'b1;
               ram_wa <= clr_addr;
               ram_wd <= '0;
               if (clr_done) state <= S_IDLE;
            end
`endif
            S_IDLE: begin
               cmd_ready <= !accept;
               ram_we    <= accept & (cmd_op == OP_WRITE) & !cmd_err;
               if (accept) begin
                  op_q    <= cmd_op;
                  err_q   <= cmd_err;
                  ram_ra1 <= cmd_addr_a;
                  ram_ra2 <= cmd_addr_b;
                  ram_wa  <= cmd_addr_a;
                  ram_wd  <= cmd_wdata;
                  state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               ram_we     <= 1'b0;
               rsp_valid  <= 1'b1;
               rsp_err    <= err_q;
               rsp_data_a <= (op_q == OP_READ && !err_q) ? ram_rd1 : '0;
               rsp_data_b <= (op_q == OP_READ && !err_q) ? ram_rd2 : '0;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  rsp_data_a <= '0;
                  rsp_data_b <= '0;
                  rsp_err    <= 1'b0;
                  op_count   <= op_count + 1'b1;
                  cmd_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               ram_we <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule
